// File: rtl/riscv_mc_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, datapath
// select values and the FSM state set.
package riscv_mc_controller_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
        ALU_OR  = 3'b011, ALU_XOR = 3'b100, ALU_SLT = 3'b101
    } alu_ctl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0, RES_MDR = 2'd1, RES_ALURESULT = 2'd2, RES_IMMEXT = 2'd3
    } result_src_t;

    typedef enum logic [1:0] { SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_REG = 2'd2 } src_a_t;
    typedef enum logic [1:0] { SRCB_REG = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2 } src_b_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_HALT
    } state_t;

    // Branch resolution from the SUB result; blt/bge use the raw sign bit.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic sign);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return sign;
            3'b101:  return !sign;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_controller_alu_decoder.sv
// Combinational ALU-operation decode plus instruction legality check
// used by the controller in DECODE and the execute states.
module riscv_mc_controller_alu_decoder
    import riscv_mc_controller_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_ctl_t   alu_control,
    output logic       legal
);

    logic is_r;
    logic funct3_ok;
    logic unused_funct7;

    assign is_r          = (op == OP_R);
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        alu_control = ALU_ADD;
        funct3_ok   = 1'b1;
        case (funct3)
            3'b000:  alu_control = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_control = ALU_AND;
            3'b110:  alu_control = ALU_OR;
            3'b100:  alu_control = ALU_XOR;
            3'b010:  alu_control = ALU_SLT;
            default: funct3_ok   = 1'b0;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R, OP_I: legal = funct3_ok;
            OP_BR:      legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                (funct3 == 3'b100) || (funct3 == 3'b101);
            OP_LW, OP_SW, OP_JAL, OP_JALR, OP_LUI: legal = 1'b1;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Control FSM for the multi-cycle RV32I datapath: sequences one instruction
// at a time and drives every datapath select and enable from the state.
module riscv_mc_controller
    import riscv_mc_controller_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       ALUResSign,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal,
    output logic       halted
);

    state_t      state, state_next;
    alu_ctl_t    dec_alu, alu_ctl;
    imm_src_t    imm_src;
    result_src_t result_src;
    src_a_t      src_a;
    src_b_t      src_b;
    logic        dec_legal;

    riscv_mc_controller_alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_alu),
        .legal       (dec_legal)
    );

    // NOTE: sequential state uses non-blocking assignment only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        result_src = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_REG;
        alu_ctl    = ALU_ADD;
        imm_src    = IMM_I;

        case (state)
            S_FETCH: begin
                IRWrite = 1'b1; PCWrite = 1'b1;
                src_b = SRCB_FOUR; result_src = RES_ALURESULT;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                src_a = SRCA_OLDPC; src_b = SRCB_IMM;
                imm_src = (op == OP_JAL) ? IMM_J : IMM_B;
                if (!dec_legal) begin
                    illegal    = 1'b1;
                    state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_R:         state_next = S_EXECR;
                        OP_I:         state_next = S_EXECI;
                        OP_BR:        state_next = S_BRANCH;
                        OP_JAL:       state_next = S_JAL;
                        OP_JALR:      state_next = S_JALR;
                        default:      state_next = S_LUI;
                    endcase
                end
            end
            S_MEMADR: begin
                src_a = SRCA_REG; src_b = SRCB_IMM;
                imm_src    = (op == OP_SW) ? IMM_S : IMM_I;
                state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1; state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MDR; RegWrite = 1'b1; state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1; MemWrite = 1'b1; state_next = S_FETCH;
            end
            S_EXECR: begin
                src_a = SRCA_REG; alu_ctl = dec_alu; state_next = S_ALUWB;
            end
            S_EXECI: begin
                src_a = SRCA_REG; src_b = SRCB_IMM; alu_ctl = dec_alu;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1; state_next = S_FETCH;
            end
            S_BRANCH: begin
                src_a = SRCA_REG; alu_ctl = ALU_SUB;
                PCWrite    = branch_taken(funct3, Zero, ALUResSign);
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC takes ALUOut (target) while the ALU forms OldPC+4 for LINK.
                PCWrite = 1'b1; src_a = SRCA_OLDPC; src_b = SRCB_FOUR;
                state_next = S_LINK;
            end
            S_JALR: begin
                src_a = SRCA_REG; src_b = SRCB_IMM; result_src = RES_ALURESULT;
                PCWrite = 1'b1; state_next = S_LINK;
            end
            S_LINK: begin
                src_a = SRCA_OLDPC; src_b = SRCB_FOUR; result_src = RES_ALURESULT;
                RegWrite = 1'b1; state_next = S_FETCH;
            end
            S_LUI: begin
                imm_src = IMM_U; result_src = RES_IMMEXT; RegWrite = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset state is FETCH; its enables must not reach the datapath while rst is low.
        if (!rst) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign ResultSrc  = result_src;
    assign ALUSrcA    = src_a;
    assign ALUSrcB    = src_b;
    assign ALUControl = alu_ctl;
    assign ImmSrc     = imm_src;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Randomized bench for riscv_mc_controller: both ILLEGAL_HALT settings run side
// by side against a per-instruction reference model of the control sequence.
module tb_riscv_mc_controller;

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LW_OP = 7'b0000011;
    localparam logic [6:0] SW_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111, LUI_OP = 7'b0110111;

    typedef struct packed {
        logic       pc, adr, mem, ir, rw;
        logic [1:0] res, a, b;
        logic [2:0] alu, imm;
        logic       ill, hlt;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic zero = 1'b0, sign = 1'b0;

    logic       PCWrite_n, AdrSrc_n, MemWrite_n, IRWrite_n, RegWrite_n, illegal_n, halted_n;
    logic [1:0] ResultSrc_n, ALUSrcA_n, ALUSrcB_n;
    logic [2:0] ALUControl_n, ImmSrc_n;
    logic       PCWrite_h, AdrSrc_h, MemWrite_h, IRWrite_h, RegWrite_h, illegal_h, halted_h;
    logic [1:0] ResultSrc_h, ALUSrcA_h, ALUSrcB_h;
    logic [2:0] ALUControl_h, ImmSrc_h;

    int   vectors = 0;
    int   errors  = 0;
    bit   h_halted = 1'b0;
    ctl_t exp_q[$];
    ctl_t obs_n, obs_h;

    always #5 clk = ~clk;

    riscv_mc_controller #(.ILLEGAL_HALT(1'b0)) dut_n (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(zero), .ALUResSign(sign),
        .PCWrite(PCWrite_n), .AdrSrc(AdrSrc_n), .MemWrite(MemWrite_n), .IRWrite(IRWrite_n),
        .RegWrite(RegWrite_n), .ResultSrc(ResultSrc_n), .ALUSrcA(ALUSrcA_n),
        .ALUSrcB(ALUSrcB_n), .ALUControl(ALUControl_n), .ImmSrc(ImmSrc_n),
        .illegal(illegal_n), .halted(halted_n)
    );

    riscv_mc_controller #(.ILLEGAL_HALT(1'b1)) dut_h (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(zero), .ALUResSign(sign),
        .PCWrite(PCWrite_h), .AdrSrc(AdrSrc_h), .MemWrite(MemWrite_h), .IRWrite(IRWrite_h),
        .RegWrite(RegWrite_h), .ResultSrc(ResultSrc_h), .ALUSrcA(ALUSrcA_h),
        .ALUSrcB(ALUSrcB_h), .ALUControl(ALUControl_h), .ImmSrc(ImmSrc_h),
        .illegal(illegal_h), .halted(halted_h)
    );

    assign obs_n = {PCWrite_n, AdrSrc_n, MemWrite_n, IRWrite_n, RegWrite_n, ResultSrc_n,
                    ALUSrcA_n, ALUSrcB_n, ALUControl_n, ImmSrc_n, illegal_n, halted_n};
    assign obs_h = {PCWrite_h, AdrSrc_h, MemWrite_h, IRWrite_h, RegWrite_h, ResultSrc_h,
                    ALUSrcA_h, ALUSrcB_h, ALUControl_h, ImmSrc_h, illegal_h, halted_h};

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t v(input bit pc, adr, mem, ir, rw,
                               input logic [1:0] res, a, b, input logic [2:0] alu, imm);
        ctl_t c;
        c = '{pc: pc, adr: adr, mem: mem, ir: ir, rw: rw, res: res, a: a, b: b,
              alu: alu, imm: imm, ill: 1'b0, hlt: 1'b0};
        return c;
    endfunction

    // Expected per-cycle control vectors for one instruction, FETCH first.
    function automatic void build(input logic [6:0] o, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic z, s, output bit ill);
        bit         ok;
        logic [2:0] alu;
        ctl_t       dec;
        exp_q.delete();
        alu = 3'd0;
        ok  = 1'b1;
        case (f3)
            3'b000:  alu = (o == R_OP && f7[5]) ? 3'd1 : 3'd0;
            3'b111:  alu = 3'd2;
            3'b110:  alu = 3'd3;
            3'b100:  alu = 3'd4;
            3'b010:  alu = 3'd5;
            default: ok = 1'b0;
        endcase
        if (o == BR_OP) ok = (f3 inside {3'b000, 3'b001, 3'b100, 3'b101});
        else if (o inside {LW_OP, SW_OP, JAL_OP, JALR_OP, LUI_OP}) ok = 1'b1;
        else if (!(o inside {R_OP, I_OP})) ok = 1'b0;
        ill = !ok;

        exp_q.push_back(v(1, 0, 0, 1, 0, 2, 0, 2, 0, 0));
        dec = v(0, 0, 0, 0, 0, 0, 1, 1, 0, (o == JAL_OP) ? 3'd3 : 3'd2);
        dec.ill = ill;
        exp_q.push_back(dec);
        if (ill) return;

        case (o)
            LW_OP: begin
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
                exp_q.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
            end
            SW_OP: begin
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 2, 1, 0, 1));
                exp_q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            R_OP, I_OP: begin
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 2, (o == I_OP) ? 2'd1 : 2'd0, alu, 0));
                exp_q.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            end
            BR_OP: begin
                bit taken;
                taken = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? s : !s;
                exp_q.push_back(v(taken, 0, 0, 0, 0, 0, 2, 0, 1, 0));
            end
            JAL_OP, JALR_OP: begin
                if (o == JAL_OP) exp_q.push_back(v(1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
                else             exp_q.push_back(v(1, 0, 0, 0, 0, 2, 2, 1, 0, 0));
                exp_q.push_back(v(0, 0, 0, 0, 1, 2, 1, 2, 0, 0));
            end
            default: exp_q.push_back(v(0, 0, 0, 0, 1, 3, 0, 0, 0, 4));
        endcase
    endfunction

    // Called one time unit after a rising edge with both DUTs in FETCH.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic s);
        bit   ill;
        ctl_t halt_v;
        halt_v = '0;
        halt_v.hlt = 1'b1;
        op = o; funct3 = f3; funct7 = f7; zero = z; sign = s;
        build(o, f3, f7, z, s, ill);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check($sformatf("%s.nohalt.c%0d", name, k), obs_n, exp_q[k]);
            check($sformatf("%s.halt.c%0d", name, k), obs_h, h_halted ? halt_v : exp_q[k]);
            @(posedge clk);
            #1;
        end
        if (ill) h_halted = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        h_halted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.en_n", 19'({PCWrite_n, MemWrite_n, IRWrite_n, RegWrite_n, illegal_n, halted_n}), 19'd0);
        check("reset.en_h", 19'({PCWrite_h, MemWrite_h, IRWrite_h, RegWrite_h, illegal_h, halted_h}), 19'd0);
        rst = 1'b1;
    endtask

    initial begin
        logic [6:0] ops [8];
        ops = '{R_OP, I_OP, LW_OP, SW_OP, BR_OP, JAL_OP, JALR_OP, LUI_OP};

        do_reset();
        run_instr("lw", LW_OP, 3'b010, 7'h00, 1'b0, 1'b0);
        run_instr("sub", R_OP, 3'b000, 7'b0100000, 1'b0, 1'b0);
        run_instr("beq_z1", BR_OP, 3'b000, 7'h00, 1'b1, 1'b0);
        run_instr("bne_z1", BR_OP, 3'b001, 7'h00, 1'b1, 1'b0);
        run_instr("blt_s1", BR_OP, 3'b100, 7'h00, 1'b0, 1'b1);
        run_instr("bge_s1", BR_OP, 3'b101, 7'h00, 1'b0, 1'b1);
        run_instr("jal", JAL_OP, 3'b000, 7'h00, 1'b0, 1'b0);
        run_instr("illegal", 7'b1111111, 3'b000, 7'h00, 1'b0, 1'b0);
        run_instr("post_ill_lw", LW_OP, 3'b010, 7'h00, 1'b0, 1'b0);
        run_instr("post_ill_r", R_OP, 3'b111, 7'h00, 1'b0, 1'b0);
        run_instr("post_ill_jal", JAL_OP, 3'b000, 7'h00, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 250; i++) begin
            logic [6:0] o, f7;
            int idx;
            idx = $urandom_range(0, 8);
            o   = (idx == 8) ? 7'($urandom) : ops[idx];
            f7  = $urandom_range(0, 1) ? ($urandom_range(0, 1) ? 7'h20 : 7'h00) : 7'($urandom);
            run_instr($sformatf("rnd%0d", i), o, 3'($urandom), f7,
                      1'($urandom), 1'($urandom));
        end

        // Reset pulled mid-MEMWRITE must kill the store immediately.
        do_reset();
        op = SW_OP; funct3 = 3'b010; funct7 = 7'h00;
        repeat (3) @(posedge clk);
        #2;
        check("sw.memwrite_before_rst", 19'(MemWrite_n), 19'd1);
        rst = 1'b0;
        #1;
        check("sw.rst_kill_n", 19'({PCWrite_n, MemWrite_n, IRWrite_n, RegWrite_n}), 19'd0);
        check("sw.rst_kill_h", 19'({PCWrite_h, MemWrite_h, IRWrite_h, RegWrite_h}), 19'd0);
        h_halted = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr("after_rst_lui", LUI_OP, 3'b000, 7'h00, 1'b0, 1'b0);
        run_instr("after_rst_jalr", JALR_OP, 3'b000, 7'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
